rect_fill_engine: RTL and testbench
===================================

Name: rect_fill_engine

Overview:
- Parametrised successor to the rectangle generator: accepts byte-serial rectangle commands from the command processor FIFO and emits word writes with per-byte enables to the frame-buffer arbiter.
- Adds configurable framebuffer geometry and bus width, a solid/outline mode, and clipping of rectangles to the frame bounds.
- Sits between the command processor FIFO and one arbiter write port.

Parameters:
- FB_WIDTH, 640, frame width in pixels; must be a multiple of PIX_PER_WORD.
- FB_HEIGHT, 480, frame height in pixels.
- DATA_W, 32, arbiter data width; one of 16/32/64. PIX_PER_WORD = DATA_W/16.
- ADDR_W, 18, arbiter word-address width; must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT/PIX_PER_WORD.

Ports:
- clk  in  1  clock.
- rst_  in  1  synchronous, active-high reset.
- cmd_fifo_data  in  8  command byte.
- cmd_fifo_rts  in  1  FIFO has a byte.
- cmd_fifo_rtr  out  1  engine accepts a byte.
- arb_data  out  DATA_W  write data.
- arb_addr  out  ADDR_W  word address.
- arb_wben  out  DATA_W/8  byte enables.
- arb_rts  out  1  write valid.
- arb_rtr  in  1  arbiter accepts the write.
- busy  out  1  high in every state except DECODE.
- done  out  1  one-cycle pulse when a command retires.

Behaviour:
- Transfer rules: cmd_xfc = cmd_fifo_rts & cmd_fifo_rtr; arb_xfc = arb_rts & arb_rtr.
- Reset: state=DECODE, byte index 0, cmd_fifo_rtr=1, arb_rts=0, arb_wben=0, arb_addr=0, arb_data=0, busy=0, done=0. Reset mid-draw abandons the command immediately and discards any partial command bytes.
- Command format: 12 bytes, MSB first.
  - b0 mode: bit0 = outline, bits 7:1 ignored.
  - b1-2 x, b3-4 y, b5-6 w, b7-8 h (all 16-bit unsigned).
  - b9 R, b10 G, b11 B: low nibble used.
- Pixel value is {4'h0,R,G,B}. arb_data is this value replicated PIX_PER_WORD times.
- DECODE: cmd_fifo_rtr=1; one byte is captured per cmd_xfc. The 12th cmd_xfc moves to CLIP and drops cmd_fifo_rtr on the next edge.
- CLIP (1 cycle):
  - Reject if w==0, h==0, x>=FB_WIDTH or y>=FB_HEIGHT; a rejected command goes to DONE.
  - Otherwise x1=min(x+w-1, FB_WIDTH-1) and y1=min(y+h-1, FB_HEIGHT-1). Use 17-bit sums so nothing wraps.
- ADDR (1 cycle): row_base = y*FB_WIDTH/PIX_PER_WORD. Word column wc = x0/PIX_PER_WORD.
- DRIVE: arb_rts=1. Latency is exactly 3 cycles from the last cmd_xfc to arb_rts high.
  - arb_addr = row_base + wc.
  - Pixel slot p of the word covers column wc*PIX_PER_WORD+p and drives byte-enable bits [2p+1:2p].
  - A slot is enabled if its column lies in [x0,x1] (solid rows), or equals x0 or x1 (outline interior rows). Interior rows are those with y0 < row < y1.
  - Outline interior rows visit only the word holding x0 and the word holding x1. They are one write if both columns share a word.
  - Outputs hold stable while arb_rts & !arb_rtr.
  - On arb_xfc, advance to the next word in the row. At row end, row_base += FB_WIDTH/PIX_PER_WORD and restart at the x0 word.
  - arb_xfc on the last word of row y1 moves to DONE with arb_rts=0 on the next edge.
- DONE (1 cycle): done=1, then DECODE with cmd_fifo_rtr=1.
- Single-row and single-column rectangles in outline mode draw identically to solid mode.
- No writes are ever issued outside the frame.

Decomposition:
- Package rect_pkg holds:
  - state encoding (DECODE, CLIP, ADDR, DRIVE, DONE);
  - command byte offsets and CMD_LEN=12;
  - mode bit index;
  - pixel packing function {4'h0,R,G,B}.
- One sub-module: rect_wben_gen. It is combinational and maps (word column, x0, x1, outline_row) to DATA_W/8 enables.
- Everything else lives in rect_fill_engine.

Test Plan:
- Solid fill x=3,y=2,w=4,h=2, R=F,G=0,B=A, defaults → six writes, data 32'h0F0A0F0A:
  - addr 641 wben 4'b1100, 642 4'hF, 643 4'b0011;
  - 961 4'b1100, 962 4'hF, 963 4'b0011;
  - then one done pulse; arb_rts first rises 3 cycles after the 12th byte.
- Outline x=0,y=0,w=5,h=3 → eight writes:
  - row 0: 0/F, 1/F, 2/0011;
  - row 1: 320/0011, 322/0011;
  - row 2: 640/F, 641/F, 642/0011.
- Clip x=638,y=479,w=10,h=10 → exactly one write: addr 153599, wben 4'hF; then done.
- Reject w=0 (and separately x=700) → no arb_rts, done pulses 2 cycles after the last byte, cmd_fifo_rtr=1 the cycle after done.
- Backpressure: arb_rtr random 30% high during solid fill → arb_addr/arb_data/arb_wben stable every stalled cycle; write sequence identical to the first scenario.
- Reset asserted after the 3rd write of the first scenario → next cycle arb_rts=0, cmd_fifo_rtr=1, busy=0. A following fresh command executes correctly from byte 0.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared types and constants for the rectangle fill engine: FSM encoding,
// command byte layout and pixel packing.
package rect_pkg;

    typedef enum logic [2:0] {
        DECODE,
        CLIP,
        ADDR,
        DRIVE,
        DONE
    } state_e;

    localparam int CMD_LEN = 12;

    typedef logic [3:0] byte_idx_t;

    // Byte positions within a command, MSB of each 16-bit field first.
    localparam byte_idx_t B_MODE   = 4'd0;
    localparam byte_idx_t B_X_HI   = 4'd1;
    localparam byte_idx_t B_X_LO   = 4'd2;
    localparam byte_idx_t B_Y_HI   = 4'd3;
    localparam byte_idx_t B_Y_LO   = 4'd4;
    localparam byte_idx_t B_W_HI   = 4'd5;
    localparam byte_idx_t B_W_LO   = 4'd6;
    localparam byte_idx_t B_H_HI   = 4'd7;
    localparam byte_idx_t B_H_LO   = 4'd8;
    localparam byte_idx_t B_R      = 4'd9;
    localparam byte_idx_t B_G      = 4'd10;
    localparam byte_idx_t B_B      = 4'd11;
    localparam byte_idx_t B_LAST   = byte_idx_t'(CMD_LEN - 1);

    localparam int MODE_OUTLINE_BIT = 0;

    function automatic logic [15:0] pack_pixel(input logic [3:0] r,
                                               input logic [3:0] g,
                                               input logic [3:0] b);
        return {4'h0, r, g, b};
    endfunction

endpackage

// File: rtl/rect_fill_engine_if.sv
// Command-FIFO and arbiter-write signals of the fill engine; master is the
// engine side, slave is the FIFO/arbiter side.
interface rect_fill_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18
);
    logic [7:0]          cmd_fifo_data;
    logic                cmd_fifo_rts;
    logic                cmd_fifo_rtr;
    logic [DATA_W-1:0]   arb_data;
    logic [ADDR_W-1:0]   arb_addr;
    logic [DATA_W/8-1:0] arb_wben;
    logic                arb_rts;
    logic                arb_rtr;

    modport master (
        input  cmd_fifo_data, cmd_fifo_rts, arb_rtr,
        output cmd_fifo_rtr, arb_data, arb_addr, arb_wben, arb_rts
    );

    modport slave (
        output cmd_fifo_data, cmd_fifo_rts, arb_rtr,
        input  cmd_fifo_rtr, arb_data, arb_addr, arb_wben, arb_rts
    );
endinterface

// File: rtl/rect_wben_gen.sv
// Per-word byte-enable generator: enables each 16-bit pixel slot whose column
// is inside [x0,x1], or only the edge columns on outline interior rows.
module rect_wben_gen #(
    parameter int DATA_W = 32
) (
    input  logic [15:0]         word_col_i,
    input  logic [15:0]         x0_i,
    input  logic [15:0]         x1_i,
    input  logic                outline_row_i,
    output logic [DATA_W/8-1:0] wben_o
);
    localparam int PIX_PER_WORD = DATA_W / 16;
    localparam int PIX_SHIFT    = $clog2(PIX_PER_WORD);

    for (genvar p = 0; p < PIX_PER_WORD; p++) begin : g_slot
        logic [16:0] col;
        logic        en;

        assign col = ({1'b0, word_col_i} << PIX_SHIFT) + 17'(p);
        assign en  = outline_row_i
                   ? ((col == {1'b0, x0_i}) || (col == {1'b0, x1_i}))
                   : ((col >= {1'b0, x0_i}) && (col <= {1'b0, x1_i}));
        assign wben_o[2*p +: 2] = {2{en}};
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: decodes 12-byte rectangle commands and streams clipped
// solid/outline word writes with per-pixel byte enables to a frame-buffer arbiter.
module rect_fill_engine
    import rect_pkg::*;
#(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 18
) (
    input  logic               clk,
    input  logic               rst_,
    rect_fill_engine_if.master bus,
    output logic               busy,
    output logic               done
);
    localparam int PIX_PER_WORD  = DATA_W / 16;
    localparam int PIX_SHIFT     = $clog2(PIX_PER_WORD);
    localparam int WORDS_PER_ROW = FB_WIDTH / PIX_PER_WORD;

    state_e              state_q, state_d;
    byte_idx_t           byte_idx_q;
    logic                mode_q;
    logic [15:0]         x_q, y_q, w_q, h_q;
    logic [3:0]          r_q, g_q, b_q;
    logic [15:0]         x1_q, y1_q, row_q, col_q;
    logic [ADDR_W-1:0]   row_base_q;

    logic                cmd_xfc, arb_xfc;
    logic [16:0]         x1_sum, y1_sum;
    logic [15:0]         x1_clip, y1_clip, wc0, wc1;
    logic                reject, outline_row, row_last_word, last_row;
    logic [DATA_W/8-1:0] wben;
    logic [15:0]         pixel;

    assign cmd_xfc = bus.cmd_fifo_rts & bus.cmd_fifo_rtr;
    assign arb_xfc = bus.arb_rts & bus.arb_rtr;

    // 17-bit sums so a far corner beyond 0xFFFF still clips instead of wrapping.
    assign x1_sum  = {1'b0, x_q} + {1'b0, w_q} - 17'd1;
    assign y1_sum  = {1'b0, y_q} + {1'b0, h_q} - 17'd1;
    assign x1_clip = (x1_sum > 17'(FB_WIDTH - 1))  ? 16'(FB_WIDTH - 1)  : x1_sum[15:0];
    assign y1_clip = (y1_sum > 17'(FB_HEIGHT - 1)) ? 16'(FB_HEIGHT - 1) : y1_sum[15:0];
    assign reject  = (w_q == 16'd0) || (h_q == 16'd0) ||
                     (x_q >= 16'(FB_WIDTH)) || (y_q >= 16'(FB_HEIGHT));

    assign wc0           = x_q >> PIX_SHIFT;
    assign wc1           = x1_q >> PIX_SHIFT;
    assign outline_row   = mode_q && (row_q > y_q) && (row_q < y1_q);
    assign row_last_word = (col_q == wc1);
    assign last_row      = (row_q == y1_q);
    assign pixel         = pack_pixel(r_q, g_q, b_q);

    rect_wben_gen #(.DATA_W(DATA_W)) u_wben_gen (
        .word_col_i    (col_q),
        .x0_i          (x_q),
        .x1_i          (x1_q),
        .outline_row_i (outline_row),
        .wben_o        (wben)
    );

    always_ff @(posedge clk) begin
        if (rst_) state_q <= DECODE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        unique case (state_q)
            DECODE:  if (cmd_xfc && byte_idx_q == B_LAST) state_d = CLIP;
            CLIP:    state_d = reject ? DONE : ADDR;
            ADDR:    state_d = DRIVE;
            DRIVE:   if (arb_xfc && row_last_word && last_row) state_d = DONE;
            DONE:    state_d = DECODE;
            default: state_d = DECODE;
        endcase
    end

    always_comb begin
        bus.cmd_fifo_rtr = 1'b0;
        bus.arb_rts      = 1'b0;
        bus.arb_addr     = '0;
        bus.arb_data     = '0;
        bus.arb_wben     = '0;
        busy             = 1'b1;
        done             = 1'b0;
        unique case (state_q)
            DECODE: begin
                bus.cmd_fifo_rtr = 1'b1;
                busy             = 1'b0;
            end
            DRIVE: begin
                bus.arb_rts  = 1'b1;
                bus.arb_addr = row_base_q + ADDR_W'(col_q);
                bus.arb_data = {PIX_PER_WORD{pixel}};
                bus.arb_wben = wben;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_)         byte_idx_q <= '0;
        else if (cmd_xfc) byte_idx_q <= (byte_idx_q == B_LAST) ? '0 : byte_idx_q + 4'd1;
    end

    // NOTE: command fields and walk counters carry no reset; they are only
    // observed in DRIVE, which is always entered through DECODE/CLIP/ADDR loads.
    always_ff @(posedge clk) begin
        if (state_q == DECODE && cmd_xfc) begin
            case (byte_idx_q)
                B_MODE:  mode_q     <= bus.cmd_fifo_data[MODE_OUTLINE_BIT];
                B_X_HI:  x_q[15:8]  <= bus.cmd_fifo_data;
                B_X_LO:  x_q[7:0]   <= bus.cmd_fifo_data;
                B_Y_HI:  y_q[15:8]  <= bus.cmd_fifo_data;
                B_Y_LO:  y_q[7:0]   <= bus.cmd_fifo_data;
                B_W_HI:  w_q[15:8]  <= bus.cmd_fifo_data;
                B_W_LO:  w_q[7:0]   <= bus.cmd_fifo_data;
                B_H_HI:  h_q[15:8]  <= bus.cmd_fifo_data;
                B_H_LO:  h_q[7:0]   <= bus.cmd_fifo_data;
                B_R:     r_q        <= bus.cmd_fifo_data[3:0];
                B_G:     g_q        <= bus.cmd_fifo_data[3:0];
                B_B:     b_q        <= bus.cmd_fifo_data[3:0];
                default: ;
            endcase
        end

        case (state_q)
            CLIP: begin
                x1_q <= x1_clip;
                y1_q <= y1_clip;
            end
            ADDR: begin
                row_base_q <= ADDR_W'(y_q) * ADDR_W'(WORDS_PER_ROW);
                col_q      <= wc0;
                row_q      <= y_q;
            end
            DRIVE: begin
                if (arb_xfc) begin
                    if (!row_last_word) begin
                        // Outline interior rows jump straight from the x0 word to the x1 word.
                        col_q <= outline_row ? wc1 : col_q + 16'd1;
                    end else if (!last_row) begin
                        row_q      <= row_q + 16'd1;
                        row_base_q <= row_base_q + ADDR_W'(WORDS_PER_ROW);
                        col_q      <= wc0;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: solid, outline, clip, reject,
// backpressure and mid-draw reset scenarios on a 640x480, 32-bit frame buffer.
module tb_rect_fill_engine;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 18;

    logic clk  = 1'b0;
    logic rst_ = 1'b1;
    logic busy;
    logic done;

    rect_fill_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rect_fill_engine #(
        .FB_WIDTH  (640),
        .FB_HEIGHT (480),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic [ADDR_W-1:0] exp_addr [16];
    logic [3:0]        exp_wben [16];
    logic [ADDR_W-1:0] got_addr [16];
    logic [3:0]        got_wben [16];
    logic [31:0]       got_data [16];
    int                n_got;
    int                n_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input int i, input logic [ADDR_W-1:0] a, input logic [3:0] wb);
        exp_addr[i] = a;
        exp_wben[i] = wb;
    endtask

    task automatic set_solid_exp();
        set_exp(0, 18'd641, 4'b1100);
        set_exp(1, 18'd642, 4'b1111);
        set_exp(2, 18'd643, 4'b0011);
        set_exp(3, 18'd961, 4'b1100);
        set_exp(4, 18'd962, 4'b1111);
        set_exp(5, 18'd963, 4'b0011);
    endtask

    task automatic set_outline_exp();
        set_exp(0, 18'd0,   4'b1111);
        set_exp(1, 18'd1,   4'b1111);
        set_exp(2, 18'd2,   4'b0011);
        set_exp(3, 18'd320, 4'b0011);
        set_exp(4, 18'd322, 4'b0011);
        set_exp(5, 18'd640, 4'b1111);
        set_exp(6, 18'd641, 4'b1111);
        set_exp(7, 18'd642, 4'b0011);
    endtask

    // Starts and ends on a falling edge; returns one cycle after the last byte's transfer.
    task automatic send_rect(input logic outline, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] w, input logic [15:0] h,
                             input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                             input bit gap);
        logic [7:0] bytes [12];
        bytes[0]  = {7'b1010110, outline};
        bytes[1]  = x[15:8];
        bytes[2]  = x[7:0];
        bytes[3]  = y[15:8];
        bytes[4]  = y[7:0];
        bytes[5]  = w[15:8];
        bytes[6]  = w[7:0];
        bytes[7]  = h[15:8];
        bytes[8]  = h[7:0];
        bytes[9]  = {4'hA, r};
        bytes[10] = {4'h5, g};
        bytes[11] = {4'hC, b};
        for (int i = 0; i < 12; i++) begin
            if (gap && i == 5) begin
                bus.cmd_fifo_rts  = 1'b0;
                bus.cmd_fifo_data = 8'hEE;
                @(negedge clk);
            end
            bus.cmd_fifo_data = bytes[i];
            bus.cmd_fifo_rts  = 1'b1;
            if (i == 0 || i == 11) check($sformatf("cmd_rtr_byte%0d", i), bus.cmd_fifo_rtr, 1'b1);
            @(negedge clk);
        end
        bus.cmd_fifo_rts = 1'b0;
    endtask

    // Drains one command's writes, checking that stalled cycles hold the outputs steady.
    task automatic collect(input bit stall, input int budget);
        logic [ADDR_W-1:0] h_addr;
        logic [3:0]        h_wben;
        logic [31:0]       h_data;
        bit                held;
        int                post;
        n_got  = 0;
        n_done = 0;
        held   = 1'b0;
        post   = 0;
        h_addr = '0;
        h_wben = '0;
        h_data = '0;
        for (int c = 0; c < budget; c++) begin
            bus.arb_rtr = stall ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (held) begin
                check("stall_rts",  bus.arb_rts,  1'b1);
                check("stall_addr", bus.arb_addr, h_addr);
                check("stall_wben", bus.arb_wben, h_wben);
                check("stall_data", bus.arb_data, h_data);
            end
            held = 1'b0;
            if (bus.arb_rts) begin
                if (bus.arb_rtr) begin
                    if (n_got < 16) begin
                        got_addr[n_got] = bus.arb_addr;
                        got_wben[n_got] = bus.arb_wben;
                        got_data[n_got] = bus.arb_data;
                    end
                    n_got++;
                end else begin
                    held   = 1'b1;
                    h_addr = bus.arb_addr;
                    h_wben = bus.arb_wben;
                    h_data = bus.arb_data;
                end
            end
            if (done) n_done++;
            @(negedge clk);
            if (n_done > 0) begin
                post++;
                if (post >= 3) break;
            end
        end
        bus.arb_rtr = 1'b0;
        check("done_pulses", n_done, 1);
        check("idle_rtr",  bus.cmd_fifo_rtr, 1'b1);
        check("idle_busy", busy, 1'b0);
    endtask

    task automatic check_writes(input string tag, input int n_exp, input logic [31:0] data_exp);
        check({tag, "_count"}, n_got, n_exp);
        for (int i = 0; i < n_exp && i < n_got; i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s_wben%0d", tag, i), got_wben[i], exp_wben[i]);
            check($sformatf("%s_data%0d", tag, i), got_data[i], data_exp);
        end
    endtask

    // Called one cycle after the last byte: CLIP now, DONE next, DECODE after that.
    task automatic check_reject(input string tag);
        check({tag, "_c1_done"}, done, 1'b0);
        check({tag, "_c1_rts"},  bus.arb_rts, 1'b0);
        @(negedge clk);
        check({tag, "_c2_done"}, done, 1'b1);
        check({tag, "_c2_rts"},  bus.arb_rts, 1'b0);
        @(negedge clk);
        check({tag, "_c3_done"}, done, 1'b0);
        check({tag, "_c3_rtr"},  bus.cmd_fifo_rtr, 1'b1);
        check({tag, "_c3_rts"},  bus.arb_rts, 1'b0);
    endtask

    initial begin
        int wr;
        bus.cmd_fifo_data = 8'h00;
        bus.cmd_fifo_rts  = 1'b0;
        bus.arb_rtr       = 1'b0;
        rst_              = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_rtr",  bus.cmd_fifo_rtr, 1'b1);
        check("rst_rts",  bus.arb_rts, 1'b0);
        check("rst_wben", bus.arb_wben, 4'h0);
        check("rst_addr", bus.arb_addr, 18'd0);
        check("rst_data", bus.arb_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_ = 1'b0;
        @(negedge clk);

        // Solid fill with the 3-cycle latency to the first write.
        send_rect(1'b0, 16'd3, 16'd2, 16'd4, 16'd2, 4'hF, 4'h0, 4'hA, 1'b0);
        check("lat_c1_rts",  bus.arb_rts, 1'b0);
        check("lat_c1_busy", busy, 1'b1);
        check("lat_c1_rtr",  bus.cmd_fifo_rtr, 1'b0);
        @(negedge clk);
        check("lat_c2_rts", bus.arb_rts, 1'b0);
        @(negedge clk);
        check("lat_c3_rts", bus.arb_rts, 1'b1);
        collect(1'b0, 100);
        set_solid_exp();
        check_writes("solid", 6, 32'h0F0A0F0A);

        // Outline, with a FIFO bubble in the middle of the command.
        send_rect(1'b1, 16'd0, 16'd0, 16'd5, 16'd3, 4'h1, 4'h2, 4'h3, 1'b1);
        collect(1'b0, 100);
        set_outline_exp();
        check_writes("outline", 8, 32'h01230123);

        // Bottom-right corner clipped to a single word.
        send_rect(1'b0, 16'd638, 16'd479, 16'd10, 16'd10, 4'h7, 4'h7, 4'h7, 1'b0);
        collect(1'b0, 100);
        set_exp(0, 18'd153599, 4'b1111);
        check_writes("clip", 1, 32'h07770777);

        send_rect(1'b0, 16'd10, 16'd10, 16'd0, 16'd5, 4'h1, 4'h1, 4'h1, 1'b0);
        check_reject("rej_w0");
        send_rect(1'b0, 16'd700, 16'd10, 16'd4, 16'd5, 4'h1, 4'h1, 4'h1, 1'b0);
        check_reject("rej_x700");

        // Same solid fill under random arbiter backpressure.
        send_rect(1'b0, 16'd3, 16'd2, 16'd4, 16'd2, 4'hF, 4'h0, 4'hA, 1'b0);
        collect(1'b1, 400);
        set_solid_exp();
        check_writes("bp", 6, 32'h0F0A0F0A);

        // Reset after the third write of the solid fill.
        send_rect(1'b0, 16'd3, 16'd2, 16'd4, 16'd2, 4'hF, 4'h0, 4'hA, 1'b0);
        bus.arb_rtr = 1'b1;
        wr = 0;
        for (int c = 0; c < 50 && wr < 3; c++) begin
            if (bus.arb_rts) wr++;
            @(negedge clk);
        end
        check("rst_mid_writes", wr, 3);
        bus.arb_rtr = 1'b0;
        rst_ = 1'b1;
        @(negedge clk);
        check("rst_mid_rts",  bus.arb_rts, 1'b0);
        check("rst_mid_rtr",  bus.cmd_fifo_rtr, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        rst_ = 1'b0;

        // A partial command abandoned by reset must not corrupt the next one.
        bus.cmd_fifo_data = 8'hFF;
        bus.cmd_fifo_rts  = 1'b1;
        repeat (5) @(negedge clk);
        bus.cmd_fifo_rts = 1'b0;
        rst_ = 1'b1;
        @(negedge clk);
        rst_ = 1'b0;
        @(negedge clk);
        send_rect(1'b1, 16'd0, 16'd0, 16'd5, 16'd3, 4'h1, 4'h2, 4'h3, 1'b0);
        collect(1'b0, 100);
        set_outline_exp();
        check_writes("post_rst", 8, 32'h01230123);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
